// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide sequencer: operation codes,
// FSM state encoding and the default operand width.
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MUL,
    OP_MULU,
    OP_DIV,
    OP_DIVU
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Controller <-> sequencer bundle: start strobes and operands in,
// busy/done status and the HI/LO registers out, plus FSM state for debug.
interface muldiv_sequencer_if #(
  parameter int WIDTH = muldiv_pkg::WIDTH_DEFAULT
) ();
  import muldiv_pkg::*;

  // Handshake: a start strobe is a one-cycle request honoured only while
  // busy is low; done pulses for one cycle with hi/lo (and div_by_zero) valid.
  logic             mul_start;
  logic             mulu_start;
  logic             div_start;
  logic             divu_start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  state_t           state;

  modport master (
    output mul_start, mulu_start, div_start, divu_start, a, b,
    input  busy, done, div_by_zero, hi, lo, state
  );

  modport slave (
    input  mul_start, mulu_start, div_start, divu_start, a, b,
    output busy, done, div_by_zero, hi, lo, state
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the loop: shift-add multiply (LSB first) or
// restoring divide on the {acc, opnd} pair.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] opnd_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  always_comb begin
    sum       = {1'b0, acc} + {1'b0, m};
    trial     = {acc, opnd[WIDTH-1]} - {1'b0, m};
    acc_next  = acc;
    opnd_next = opnd;
    if (is_div) begin
      // Partial remainder is always below the divisor, so the shifted
      // value fits in WIDTH+1 bits and the MSB of trial is the borrow.
      if (!trial[WIDTH]) begin
        acc_next  = trial[WIDTH-1:0];
        opnd_next = {opnd[WIDTH-2:0], 1'b1};
      end else begin
        acc_next  = {acc[WIDTH-2:0], opnd[WIDTH-1]};
        opnd_next = {opnd[WIDTH-2:0], 1'b0};
      end
    end else if (opnd[0]) begin
      acc_next  = sum[WIDTH:1];
      opnd_next = {sum[0], opnd[WIDTH-1:1]};
    end else begin
      acc_next  = {1'b0, acc[WIDTH-1:1]};
      opnd_next = {acc[0], opnd[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MUL/MULU/DIV/DIVU sequencer owning the HI/LO registers.
// Magnitudes are iterated for WIDTH cycles; signs are fixed in one extra cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  op_t              op;
  logic             sign_a;
  logic             sign_b;
  logic             b_zero;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             done;
  logic             dbz;

  op_t              start_op;
  logic             any_start;
  logic             start_signed;
  logic             start_div;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             is_div;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] opnd_next;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;
  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    start_op  = OP_MULU;
    any_start = bus.div_start | bus.divu_start | bus.mul_start | bus.mulu_start;
    if (bus.div_start)       start_op = OP_DIV;
    else if (bus.divu_start) start_op = OP_DIVU;
    else if (bus.mul_start)  start_op = OP_MUL;
    start_signed = (start_op == OP_MUL) || (start_op == OP_DIV);
    start_div    = (start_op == OP_DIV) || (start_op == OP_DIVU);
    a_mag = (start_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag = (start_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  assign is_div = (op == OP_DIV) || (op == OP_DIVU);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div    (is_div),
    .acc       (acc),
    .opnd      (opnd),
    .m         (m),
    .acc_next  (acc_next),
    .opnd_next (opnd_next)
  );

  assign prod_neg = -{acc, opnd};

  always_comb begin
    fix_hi = acc;
    fix_lo = opnd;
    if (is_div && b_zero) begin
      fix_hi = a_raw;
      fix_lo = '1;
    end else if (op == OP_MUL && (sign_a ^ sign_b)) begin
      {fix_hi, fix_lo} = prod_neg;
    end else if (op == OP_DIV) begin
      // Quotient truncates toward zero; remainder follows the dividend.
      if (sign_a ^ sign_b) fix_lo = -opnd;
      if (sign_a)          fix_hi = -acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op     <= OP_MUL;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      cnt    <= '0;
      a_raw  <= '0;
      acc    <= '0;
      opnd   <= '0;
      m      <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      done <= 1'b0;
      dbz  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_start) begin
            op     <= start_op;
            sign_a <= bus.a[WIDTH-1];
            sign_b <= bus.b[WIDTH-1];
            b_zero <= (bus.b == '0);
            a_raw  <= bus.a;
            acc    <= '0;
            opnd   <= start_div ? a_mag : b_mag;
            m      <= start_div ? b_mag : a_mag;
            cnt    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          acc  <= acc_next;
          opnd <= opnd_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          dbz   <= is_div && b_zero;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done;
  assign bus.div_by_zero = dbz;
  assign bus.hi          = hi;
  assign bus.lo          = lo;
  assign bus.state       = state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed cases, randomized ops against an
// arithmetic reference model, busy-strobe, mid-op reset and priority scenarios.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: plain integer arithmetic.
  function automatic void model(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo,
                                output logic dbz);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    int              ia, ib;
    dbz = 1'b0;
    hi  = '0;
    lo  = '0;
    case (op)
      OP_MUL: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sp = sa * sb;
        {hi, lo} = sp;
      end
      OP_MULU: begin
        ua = {32'd0, a};
        ub = {32'd0, b};
        up = ua * ub;
        {hi, lo} = up;
      end
      OP_DIV: begin
        ia = a;
        ib = b;
        if (b == 0) begin
          lo = '1; hi = a; dbz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000; hi = '0;
        end else begin
          lo = ia / ib;
          hi = ia % ib;
        end
      end
      default: begin
        if (b == 0) begin
          lo = '1; hi = a; dbz = 1'b1;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  task automatic clear_strobes();
    bus.mul_start  = 1'b0;
    bus.mulu_start = 1'b0;
    bus.div_start  = 1'b0;
    bus.divu_start = 1'b0;
  endtask

  task automatic pulse(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    clear_strobes();
    case (op)
      OP_MUL:  bus.mul_start  = 1'b1;
      OP_MULU: bus.mulu_start = 1'b1;
      OP_DIV:  bus.div_start  = 1'b1;
      default: bus.divu_start = 1'b1;
    endcase
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    clear_strobes();
  endtask

  // Samples #1 after each edge until done is seen; counts busy cycles before it.
  task automatic wait_done(output int busy_cycles, output bit got);
    busy_cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (bus.busy) busy_cycles++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] hi, output logic [W-1:0] lo,
                        output logic dbz, output int bc, output bit got);
    pulse(op, a, b);
    wait_done(bc, got);
    hi  = bus.hi;
    lo  = bus.lo;
    dbz = bus.div_by_zero;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.mul_start = 1'b1;
    bus.a = 32'd3;
    bus.b = 32'd4;
    repeat (2) @(posedge clk);
    #1;
    clear_strobes();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    vectors++;
    if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
      errors++; $display("FAIL reset_done got=%b/%b exp=0/0", bus.done, bus.div_by_zero);
    end
    vectors++;
    if (bus.hi !== '0 || bus.lo !== '0) begin
      errors++; $display("FAIL reset_hilo got=%h/%h exp=0/0", bus.hi, bus.lo);
    end
    vectors++;
    if (bus.state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=IDLE", bus.state); end
  endtask

  task automatic test_directed();
    op_t         ops[5]  = '{OP_MULU, OP_MUL, OP_DIV, OP_DIVU, OP_DIVU};
    logic [W-1:0] as[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'd5};
    logic [W-1:0] bs[5]  = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd7, 32'd0};
    logic [W-1:0] ehi[5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd5};
    logic [W-1:0] elo[5] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF};
    logic         edz[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] hi, lo;
    logic dbz;
    int bc;
    bit got;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], hi, lo, dbz, bc, got);
      vectors++;
      if (!got) begin errors++; $display("FAIL dir%0d_done got=timeout exp=done", i); end
      vectors++;
      if (bc != W + 1) begin errors++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bc, W + 1); end
      vectors++;
      if (hi !== ehi[i] || lo !== elo[i]) begin
        errors++; $display("FAIL dir%0d_result got=%h/%h exp=%h/%h", i, hi, lo, ehi[i], elo[i]);
      end
      vectors++;
      if (dbz !== edz[i]) begin errors++; $display("FAIL dir%0d_dbz got=%b exp=%b", i, dbz, edz[i]); end
      vectors++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_at_done got=1 exp=0", i); end
      @(posedge clk);
      #1;
      vectors++;
      if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
        errors++; $display("FAIL dir%0d_pulse_width got=%b/%b exp=0/0", i, bus.done, bus.div_by_zero);
      end
      vectors++;
      if (bus.hi !== ehi[i] || bus.lo !== elo[i]) begin
        errors++; $display("FAIL dir%0d_hold got=%h/%h exp=%h/%h", i, bus.hi, bus.lo, ehi[i], elo[i]);
      end
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return W'($urandom_range(0, 20));
      5:       return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [W-1:0] a, b, hi, lo, ehi, elo;
    logic dbz, edz;
    op_t op;
    int bc;
    bit got;
    for (int i = 0; i < 60; i++) begin
      op = op_t'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      model(op, a, b, ehi, elo, edz);
      run_op(op, a, b, hi, lo, dbz, bc, got);
      vectors++;
      if (!got || hi !== ehi || lo !== elo || dbz !== edz) begin
        errors++;
        $display("FAIL rand%0d op=%0d a=%h b=%h got=%h/%h/%b done=%b exp=%h/%h/%b",
                 i, op, a, b, hi, lo, dbz, got, ehi, elo, edz);
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [W-1:0] ehi, elo;
    logic edz;
    int bc;
    bit got, extra;
    model(OP_MUL, 32'd1234, -32'd5678, ehi, elo, edz);
    pulse(OP_MUL, 32'd1234, -32'd5678);
    repeat (5) @(posedge clk);
    pulse(OP_DIV, 32'd100, 32'd3);
    wait_done(bc, got);
    vectors++;
    if (!got) begin errors++; $display("FAIL busy_ign_done got=timeout exp=done"); end
    vectors++;
    if (bus.hi !== ehi || bus.lo !== elo || bus.div_by_zero !== 1'b0) begin
      errors++; $display("FAIL busy_ign_result got=%h/%h exp=%h/%h", bus.hi, bus.lo, ehi, elo);
    end
    extra = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) extra = 1'b1;
    end
    vectors++;
    if (extra) begin errors++; $display("FAIL busy_ign_queued got=extra_op exp=none"); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    pulse(OP_MULU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
    vectors++;
    if (bus.hi !== '0 || bus.lo !== '0) begin
      errors++; $display("FAIL rst_mid_hilo got=%h/%h exp=0/0", bus.hi, bus.lo);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (seen) begin errors++; $display("FAIL rst_mid_done got=1 exp=0"); end
  endtask

  task automatic test_priority();
    logic [W-1:0] ehi, elo;
    logic edz;
    int bc;
    bit got;
    model(OP_DIV, 32'hFFFF_FFF9, 32'd2, ehi, elo, edz);
    @(negedge clk);
    bus.mul_start = 1'b1;
    bus.div_start = 1'b1;
    bus.a = 32'hFFFF_FFF9;
    bus.b = 32'd2;
    @(posedge clk);
    #1;
    clear_strobes();
    wait_done(bc, got);
    vectors++;
    if (!got || bus.hi !== ehi || bus.lo !== elo) begin
      errors++; $display("FAIL priority got=%h/%h done=%b exp=%h/%h", bus.hi, bus.lo, got, ehi, elo);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, hi, lo, ehi, elo;
    logic dbz, edz;
    op_t op;
    int bc;
    bit got;
    for (int i = 0; i < 4; i++) begin
      op = op_t'(i);
      a  = $urandom;
      b  = W'($urandom_range(1, 1000));
      model(op, a, b, ehi, elo, edz);
      run_op(op, a, b, hi, lo, dbz, bc, got);
      vectors++;
      if (!got || bc != W + 1 || hi !== ehi || lo !== elo || dbz !== edz) begin
        errors++;
        $display("FAIL b2b%0d got=%h/%h busy=%0d done=%b exp=%h/%h busy=%0d",
                 i, hi, lo, bc, got, ehi, elo, W + 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_strobes();
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_busy();
    test_reset_mid();
    test_priority();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
